frame_encoder_mc: RTL and testbench

FRAME_ENCODER_MC -- requirements
Module: frame_encoder_mc

---
 rtl/frame_encoder_mc.sv | 165 ++++++++++++++++
 tb/tb_frame_encoder_mc.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_encoder_mc.sv
// Frame encoder: raster-scans one frame into an SRAM buffer, tagging pixels covered by car sprites
// with the owning car index and the car's heading sector.
module frame_encoder_mc #(
  parameter int unsigned H_RES    = 640,
  parameter int unsigned V_RES    = 480,
  parameter int unsigned NUM_CARS = 2,
  parameter int unsigned SPR      = 16,
  parameter logic [15:0] BG_COLOR = 16'h0000
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic                     i_buf_sel,
  input  logic [NUM_CARS*16-1:0]   i_car_x,
  input  logic [NUM_CARS*16-1:0]   i_car_y,
  input  logic [NUM_CARS*32-1:0]   i_car_angle,
  input  logic                     i_sram_ready,
  output logic                     o_sram_we,
  output logic [19:0]              o_sram_addr,
  output logic [15:0]              o_sram_data,
  output logic [31:0]              o_proc_counter,
  output logic [31:0]              o_pixel_counter,
  output logic                     o_opacity,
  output logic                     o_opacity_valid,
  output logic                     o_busy,
  output logic                     o_done
);

  localparam logic [19:0] BufBase = 20'(H_RES * V_RES);
  localparam logic [15:0] XLast   = 16'(H_RES - 1);
  localparam logic [15:0] YLast   = 16'(V_RES - 1);
  localparam logic [16:0] SprExt  = 17'(SPR - 1);

  typedef enum logic [1:0] {StIdle, StLatch, StRun, StDone} state_e;

  state_e state_q, state_d;

  logic [NUM_CARS*16-1:0] car_x_q, car_y_q;
  logic [NUM_CARS*3-1:0]  sector_q;
  logic [15:0]            x_q, y_q;
  logic [19:0]            addr_q;
  logic [31:0]            proc_cnt_q, pix_cnt_q;

  logic run, accept, last_pix;
  logic [NUM_CARS-1:0] car_hit;
  logic                hit;
  logic [2:0]          hit_idx, hit_sec;

  assign run      = (state_q == StRun);
  assign accept   = run & i_sram_ready;
  assign last_pix = (x_q == XLast) && (y_q == YLast);

  // Sector by threshold comparison; valid for inputs in [-360, 719].
  function automatic logic [2:0] angle_sector(input logic signed [31:0] a);
    logic signed [31:0] n;
    logic [2:0]         s;
    if (a < 0) begin
      n = a + 360;
    end else if (a >= 360) begin
      n = a - 360;
    end else begin
      n = a;
    end
    s = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (n >= 45 * k) s = 3'(k);
    end
    return s;
  endfunction

  // 17-bit compares so a sprite hanging off the right/bottom edge clips instead of wrapping.
  for (genvar g = 0; g < NUM_CARS; g++) begin : g_car_hit
    logic [16:0] cx, cy, px, py;
    assign cx = {1'b0, car_x_q[g*16 +: 16]};
    assign cy = {1'b0, car_y_q[g*16 +: 16]};
    assign px = {1'b0, x_q};
    assign py = {1'b0, y_q};
    assign car_hit[g] = (px >= cx) && (px <= cx + SprExt) && (py >= cy) && (py <= cy + SprExt);
  end

  // Scan from the top index down so the lowest covering car wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = 3'd0;
    hit_sec = 3'd0;
    for (int i = NUM_CARS - 1; i >= 0; i--) begin
      if (car_hit[i]) begin
        hit     = 1'b1;
        hit_idx = 3'(i);
        hit_sec = sector_q[i*3 +: 3];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (i_start) state_d = StLatch;
      StLatch: state_d = StRun;
      StRun:   if (accept && last_pix) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    o_sram_we       = run;
    o_sram_addr     = run ? addr_q : 20'd0;
    o_sram_data     = 16'd0;
    if (run) o_sram_data = hit ? {1'b1, hit_idx, hit_sec, 9'd0} : BG_COLOR;
    o_opacity       = run & hit;
    o_opacity_valid = run & i_sram_ready;
    o_busy          = (state_q == StLatch) || run;
    o_done          = (state_q == StDone);
  end

  assign o_proc_counter  = proc_cnt_q;
  assign o_pixel_counter = pix_cnt_q;

  // Address advances by one per accepted pixel, matching the x-inner raster order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      car_x_q    <= '0;
      car_y_q    <= '0;
      sector_q   <= '0;
      x_q        <= '0;
      y_q        <= '0;
      addr_q     <= '0;
      proc_cnt_q <= '0;
      pix_cnt_q  <= '0;
    end else if (state_q == StLatch) begin
      car_x_q <= i_car_x;
      car_y_q <= i_car_y;
      for (int i = 0; i < NUM_CARS; i++) begin
        sector_q[i*3 +: 3] <= angle_sector(i_car_angle[i*32 +: 32]);
      end
      x_q        <= '0;
      y_q        <= '0;
      addr_q     <= i_buf_sel ? BufBase : 20'd0;
      proc_cnt_q <= '0;
      pix_cnt_q  <= '0;
    end else if (run) begin
      proc_cnt_q <= proc_cnt_q + 32'd1;
      if (i_sram_ready) begin
        pix_cnt_q <= pix_cnt_q + 32'd1;
        addr_q    <= addr_q + 20'd1;
        if (x_q == XLast) begin
          x_q <= '0;
          y_q <= y_q + 16'd1;
        end else begin
          x_q <= x_q + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_encoder_mc.sv
// Scoreboard bench for frame_encoder_mc on an 8x4 frame with two 2x2 sprites.
module tb_frame_encoder_mc;

  localparam int H    = 8;
  localparam int V    = 4;
  localparam int NC   = 2;
  localparam int S    = 2;
  localparam int NPIX = H * V;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        buf_sel = 1'b0;
  logic [31:0] car_x = '0;
  logic [31:0] car_y = '0;
  logic [63:0] car_angle = '0;
  logic        ready = 1'b1;
  logic        sram_we, opacity, opacity_valid, busy, done;
  logic [19:0] sram_addr;
  logic [15:0] sram_data;
  logic [31:0] proc_counter, pixel_counter;

  frame_encoder_mc #(
    .H_RES(H), .V_RES(V), .NUM_CARS(NC), .SPR(S), .BG_COLOR(16'h0000)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_start         (start),
    .i_buf_sel       (buf_sel),
    .i_car_x         (car_x),
    .i_car_y         (car_y),
    .i_car_angle     (car_angle),
    .i_sram_ready    (ready),
    .o_sram_we       (sram_we),
    .o_sram_addr     (sram_addr),
    .o_sram_data     (sram_data),
    .o_proc_counter  (proc_counter),
    .o_pixel_counter (pixel_counter),
    .o_opacity       (opacity),
    .o_opacity_valid (opacity_valid),
    .o_busy          (busy),
    .o_done          (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] addr;
    logic [15:0] data;
    logic        opac;
  } pix_t;

  pix_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          done_cnt = 0;
  int          ready_mode = 0;
  int          stall_n = 0;
  int          run_cycles = 0;
  logic [15:0] mem [0:63];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: whole-frame expectation from the coverage/priority/sector rules.
  task automatic push_frame(input logic [31:0] px, input logic [31:0] py,
                            input logic [63:0] pa, input bit bsel);
    int base;
    base = bsel ? NPIX : 0;
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) begin
        pix_t p;
        p.addr = 20'(base + y * H + x);
        p.data = 16'h0000;
        p.opac = 1'b0;
        for (int i = NC - 1; i >= 0; i--) begin
          int cx, cy, a;
          cx = int'(px[i*16 +: 16]);
          cy = int'(py[i*16 +: 16]);
          a  = $signed(pa[i*32 +: 32]);
          if (x >= cx && x <= cx + S - 1 && y >= cy && y <= cy + S - 1) begin
            if (a < 0) a = a + 360;
            else if (a >= 360) a = a - 360;
            p.data = 16'(32'h8000 | (i << 12) | ((a / 45) << 9));
            p.opac = 1'b1;
          end
        end
        exp_q.push_back(p);
      end
    end
  endtask

  // Monitor: pops the scoreboard on every accepted write and checks stall stability.
  initial begin
    bit          held;
    logic [19:0] h_addr;
    logic [15:0] h_data;
    pix_t        p;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 1'b0;
        run_cycles = 0;
      end else begin
        check("opacity_valid", 32'(opacity_valid), 32'(sram_we & ready));
        if (sram_we) begin
          run_cycles++;
          if (held) begin
            check("hold_addr", 32'(sram_addr), 32'(h_addr));
            check("hold_data", 32'(sram_data), 32'(h_data));
          end
          if (ready) begin
            if (exp_q.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL unexpected_write: addr %0h data %0h, expected no write",
                       sram_addr, sram_data);
            end else begin
              p = exp_q.pop_front();
              check("addr", 32'(sram_addr), 32'(p.addr));
              check("data", 32'(sram_data), 32'(p.data));
              check("opacity", 32'(opacity), 32'(p.opac));
            end
            mem[sram_addr[5:0]] = sram_data;
            held = 1'b0;
          end else begin
            held   = 1'b1;
            h_addr = sram_addr;
            h_data = sram_data;
          end
        end
        if (done) begin
          check("done_pixel_counter", pixel_counter, 32'(NPIX));
          check("done_proc_counter", proc_counter, 32'(run_cycles));
          run_cycles = 0;
          done_cnt++;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: ready = 1'b1;
        1: ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (sram_we && pixel_counter == 32'd5 && stall_n < 3) begin
            ready = 1'b0;
            stall_n++;
          end else begin
            ready = 1'b1;
          end
        end
      endcase
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = 16'hDEAD;
  endtask

  task automatic start_frame(input logic [31:0] px, input logic [31:0] py,
                             input logic [63:0] pa, input bit bsel);
    @(posedge clk);
    #1;
    car_x     = px;
    car_y     = py;
    car_angle = pa;
    buf_sel   = bsel;
    start     = 1'b1;
    push_frame(px, py, pa, bsel);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int snap, n;
    snap = done_cnt;
    n = 0;
    while (done_cnt == snap && n < limit) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt == snap) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: no o_done within %0d cycles, expected one", limit);
    end
  endtask

  task automatic run_frame(input logic [31:0] px, input logic [31:0] py,
                           input logic [63:0] pa, input bit bsel);
    start_frame(px, py, pa, bsel);
    wait_done(1000);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic idle_no_write(input int cycles, input string name);
    int writes;
    writes = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (sram_we) writes++;
    end
    check(name, 32'(writes), 32'd0);
  endtask

  initial begin
    int snap, n;
    clear_mem();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_we", 32'(sram_we), 32'd0);
    check("rst_addr", 32'(sram_addr), 32'd0);
    check("rst_data", 32'(sram_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_proc", proc_counter, 32'd0);
    check("rst_pix", pixel_counter, 32'd0);
    #1 rst_n = 1'b1;
    idle_no_write(5, "no_write_before_start");

    // Two separated cars; a stray start mid-frame must be ignored.
    clear_mem();
    snap = done_cnt;
    start_frame({16'd6, 16'd1}, {16'd2, 16'd1}, {32'd120, 32'd60}, 1'b0);
    repeat (5) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(1000);
    repeat (4) @(posedge clk);
    check("single_done_pulse", 32'(done_cnt - snap), 32'd1);
    check("mem9", 32'(mem[9]), 32'h8200);
    check("mem22", 32'(mem[22]), 32'h9400);
    check("mem0", 32'(mem[0]), 32'h0000);
    check("proc_hold", proc_counter, 32'd32);
    check("pix_hold", pixel_counter, 32'd32);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    // Overlapping cars, negative angle: car0 at 270 deg -> sector 6 wins.
    clear_mem();
    run_frame({16'd3, 16'd2}, {16'd1, 16'd1}, {32'd0, 32'hFFFF_FFA6}, 1'b0);
    check("mem11_overlap", 32'(mem[11]), 32'h8C00);

    // Upper buffer, sprite clipped at the bottom-right corner.
    clear_mem();
    run_frame({16'd100, 16'd7}, {16'd100, 16'd3}, {32'd0, 32'd359}, 1'b1);
    check("mem63_corner", 32'(mem[63]), 32'h8E00);
    check("mem32_nowrap", 32'(mem[32]), 32'h0000);

    // Three-cycle stall on pixel 5.
    ready_mode = 2;
    stall_n = 0;
    run_frame({16'd6, 16'd1}, {16'd2, 16'd1}, {32'd120, 32'd60}, 1'b0);
    @(negedge clk);
    check("stall_proc", proc_counter, 32'd35);
    check("stall_pix", pixel_counter, 32'd32);
    ready_mode = 0;

    // Asynchronous reset mid-frame, then a fresh frame from address 0.
    start_frame({16'd0, 16'd4}, {16'd0, 16'd1}, {32'd300, 32'd45}, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (pixel_counter != 32'd10 && n < 200);
    check("reach_pixel10", pixel_counter, 32'd10);
    #2 rst_n = 1'b0;
    #1;
    check("arst_we", 32'(sram_we), 32'd0);
    check("arst_addr", 32'(sram_addr), 32'd0);
    check("arst_data", 32'(sram_data), 32'd0);
    check("arst_opacity", 32'(opacity), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_pix", pixel_counter, 32'd0);
    check("arst_proc", proc_counter, 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle_no_write(5, "no_write_after_reset");
    run_frame({16'd0, 16'd4}, {16'd0, 16'd1}, {32'd300, 32'd45}, 1'b0);

    // Start held high: back-to-back frames; mid-frame car_x change only hits the next frame.
    @(posedge clk);
    #1;
    car_x = {16'd5, 16'd0};
    car_y = {16'd2, 16'd0};
    car_angle = {32'd200, 32'hFFFF_FEA2};
    buf_sel = 1'b0;
    start = 1'b1;
    push_frame(car_x, car_y, car_angle, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sram_we && n < 50);
    check("b2b_first_write", 32'(sram_we), 32'd1);
    @(posedge clk);
    #1 car_x = {16'd2, 16'd6};
    push_frame(car_x, car_y, car_angle, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 200);
    check("b2b_done1", 32'(done), 32'd1);
    @(negedge clk);
    check("b2b_idle_gap", 32'({busy, done}), 32'd0);
    @(negedge clk);
    check("b2b_latch", 32'({busy, sram_we}), 32'b10);
    @(negedge clk);
    check("b2b_run", 32'(sram_we), 32'd1);
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(1000);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    idle_no_write(6, "no_third_frame");

    // Randomized frames under random back-pressure.
    ready_mode = 1;
    for (int f = 0; f < 8; f++) begin
      logic [31:0] rx, ry;
      logic [63:0] ra;
      rx = {16'($urandom_range(0, 9)), 16'($urandom_range(0, 9))};
      ry = {16'($urandom_range(0, 5)), 16'($urandom_range(0, 5))};
      ra = {32'($urandom_range(0, 1079)) - 32'd360, 32'($urandom_range(0, 1079)) - 32'd360};
      run_frame(rx, ry, ra, 1'($urandom_range(0, 1)));
    end
    ready_mode = 0;
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
